// File: rtl/flash_read.sv
// NOR flash array-read engine: Read Array command, then rd_len async reads.
// Ports: clk/rst, read_en/rd_addr/rd_len, busy/read_done, FIFO side, flash pins.
module flash_read #(
  parameter int T_VLVH = 2,
  parameter int T_DVWH = 2,
  parameter int T_WLWH = 3,
  parameter int T_WHWL = 3,
  parameter int T_AVQV = 8,
  parameter int T_EHEL = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_en,
  input  logic [24:0] rd_addr,
  input  logic [15:0] rd_len,
  output logic        busy,
  output logic        read_done,
  output logic [15:0] read_out,
  output logic        fifo_wr,
  input  logic        fifo_full,
  output logic [24:0] A,
  input  logic [15:0] dq_i,
  output logic [15:0] dq_o,
  output logic        dqe,
  output logic        oe,
  output logic        ce,
  output logic        we,
  output logic        adv,
  output logic        wp,
  output logic        rst_f
);

  localparam int T_HOLD = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD_ADV,
    S_CMD_WE,
    S_CMD_DATA,
    S_CMD_HOLD,
    S_CMD_REC,
    S_RD_ADDR,
    S_RD_OE,
    S_RD_SAMPLE,
    S_PUSH,
    S_RD_END,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [7:0]  w_len;
  logic        w_last;
  logic [24:0] r_cur_addr;
  logic [15:0] r_remain;
  logic [15:0] r_read_out;
  logic        r_rst_f;

  // Length of the current wait state; untimed states use 1.
  always_comb begin
    w_len = 8'd1;
    unique case (r_state)
      S_CMD_ADV:  w_len = 8'(T_VLVH);
      S_RD_ADDR:  w_len = 8'(T_VLVH);
      S_CMD_WE:   w_len = 8'(T_DVWH);
      S_CMD_DATA: w_len = 8'(T_WLWH);
      S_CMD_HOLD: w_len = 8'(T_HOLD);
      S_CMD_REC:  w_len = 8'(T_WHWL);
      S_RD_OE:    w_len = 8'(T_AVQV);
      S_RD_END:   w_len = 8'(T_EHEL);
      default:    w_len = 8'd1;
    endcase
  end

  assign w_last = (r_cnt == w_len - 8'd1);

  // State register; counter restarts on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (read_en) w_next = S_CMD_ADV;
      S_CMD_ADV:   if (w_last) w_next = S_CMD_WE;
      S_CMD_WE:    if (w_last) w_next = S_CMD_DATA;
      S_CMD_DATA:  if (w_last) w_next = S_CMD_HOLD;
      S_CMD_HOLD:  if (w_last) w_next = S_CMD_REC;
      S_CMD_REC:
        if (w_last)
          w_next = (r_remain == 16'd0) ? S_DONE : S_RD_ADDR;
      S_RD_ADDR:   if (w_last) w_next = S_RD_OE;
      S_RD_OE:     if (w_last) w_next = S_RD_SAMPLE;
      S_RD_SAMPLE: w_next = S_PUSH;
      S_PUSH:      if (!fifo_full) w_next = S_RD_END;
      // remain==1 here means the decremented count reaches zero
      S_RD_END:
        if (w_last)
          w_next = (r_remain == 16'd1) ? S_DONE : S_RD_ADDR;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Burst datapath and flash reset pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_addr <= 25'd0;
      r_remain   <= 16'd0;
      r_read_out <= 16'd0;
      r_rst_f    <= 1'b0;
    end else begin
      r_rst_f <= 1'b1;
      if (r_state == S_IDLE && read_en) begin
        r_cur_addr <= rd_addr;
        r_remain   <= rd_len;
      end
      if (r_state == S_RD_SAMPLE)
        r_read_out <= dq_i;
      if (r_state == S_RD_END && w_last) begin
        r_remain   <= r_remain - 16'd1;
        r_cur_addr <= r_cur_addr + 25'd1;
      end
    end
  end

  // Output decode from state.
  always_comb begin
    A         = 25'd0;
    dq_o      = 16'd0;
    dqe       = 1'b0;
    oe        = 1'b1;
    ce        = 1'b1;
    we        = 1'b1;
    adv       = 1'b1;
    fifo_wr   = 1'b0;
    read_done = 1'b0;
    unique case (r_state)
      S_CMD_ADV: begin
        A   = r_cur_addr;
        ce  = 1'b0;
        adv = 1'b0;
      end
      S_CMD_WE: begin
        A  = r_cur_addr;
        ce = 1'b0;
        we = 1'b0;
      end
      S_CMD_DATA: begin
        A    = r_cur_addr;
        ce   = 1'b0;
        we   = 1'b0;
        dq_o = 16'h00FF;
        dqe  = 1'b1;
      end
      S_CMD_HOLD: begin
        A    = r_cur_addr;
        dq_o = 16'h00FF;
        dqe  = 1'b1;
      end
      S_CMD_REC: A = r_cur_addr;
      S_RD_ADDR: begin
        A   = r_cur_addr;
        ce  = 1'b0;
        adv = 1'b0;
      end
      S_RD_OE, S_RD_SAMPLE: begin
        A  = r_cur_addr;
        ce = 1'b0;
        oe = 1'b0;
      end
      S_PUSH: begin
        A       = r_cur_addr;
        ce      = 1'b0;
        oe      = 1'b0;
        fifo_wr = !fifo_full;
      end
      S_DONE:  read_done = 1'b1;
      default: ;
    endcase
  end

  assign busy     = (r_state != S_IDLE);
  assign read_out = r_read_out;
  assign rst_f    = r_rst_f;
  assign wp       = 1'b1;

endmodule
